// File: rtl/mem_pkg.sv
// Shared definitions for the memory-stage bus sequencer: FSM states,
// load/store funct3 encodings, fault cause codes and store lane helpers.
package mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,  // no bus access outstanding
    S_REQ  = 2'b01,  // request raised, waiting for dmem_gnt
    S_RESP = 2'b10   // load granted, waiting for dmem_rvalid
  } state_t;

  // funct3 encodings of the RV32I loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // ResultSrc value that selects memory data in writeback
  localparam logic [1:0] RESULT_MEM = 2'b01;

  // FaultCauseM encodings
  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  // Classify a memory access before it reaches the bus. An undefined
  // encoding has no meaningful width, so it is reported ahead of alignment.
  function automatic logic [1:0] access_fault(input logic       is_load,
                                              input logic [2:0] funct3,
                                              input logic [1:0] addr_lo);
    logic illegal;
    logic misaligned;
    if (is_load) illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    else         illegal = (funct3 > F3_W);
    misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
    if (illegal)         return CAUSE_ILLEGAL;
    else if (misaligned) return CAUSE_MISALIGN;
    else                 return CAUSE_NONE;
  endfunction

  // Byte enables of a store; size_sel is funct3[1:0] (byte/half/word).
  function automatic logic [3:0] store_be(input logic [1:0] size_sel,
                                          input logic [1:0] addr_lo);
    case (size_sel)
      2'b00:   return 4'b0001 << addr_lo;
      2'b01:   return 4'b0011 << {addr_lo[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  // Store data replicated across every lane so the enables alone pick the bytes.
  function automatic logic [31:0] store_wdata(input logic [1:0]  size_sel,
                                              input logic [31:0] data);
    case (size_sel)
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed lane of a returned bus word and sign- or
// zero-extends it to 32 bits according to the load funct3.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane select followed by width/sign extension.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path
    // (defaults first); a missed branch would otherwise infer a latch.
    byte_lane = rdata[7:0];
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    result    = rdata;
    case (addr_lo)
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      2'd3:    byte_lane = rdata[31:24];
      default: byte_lane = rdata[7:0];
    endcase
    case (funct3)
      F3_B:    result = {{24{byte_lane[7]}}, byte_lane};
      F3_H:    result = {{16{half_lane[15]}}, half_lane};
      F3_BU:   result = {24'h0, byte_lane};
      F3_HU:   result = {16'h0, half_lane};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/memory_cycle.sv
// Memory stage of a 5-stage RV32I pipeline: sequences loads and stores over
// a req/gnt/rvalid data bus, stalls upstream while an access is in flight,
// reports alignment/encoding/timeout faults and holds the MEM/WB register.
module memory_cycle
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  // EX/MEM values, held stable upstream while StallM is high
  input  logic        RegWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [4:0]  RdM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCPlus4M,
  // MEM/WB register
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [4:0]  RdW,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
  // data bus
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  // pipeline control
  output logic        StallM,
  output logic        FaultM,
  output logic [1:0]  FaultCauseM
);

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt;
  logic          is_store, is_load, mem_op, legal_op;
  logic [1:0]    check_cause;
  logic          req, stall, fault, load_done;
  logic [1:0]    cause;
  logic [31:0]   load_data;

  // Access classification; a store wins if both flags are raised.
  assign is_store    = MemWriteM;
  assign is_load     = (ResultSrcM == RESULT_MEM) && !MemWriteM;
  assign mem_op      = is_store || is_load;
  assign check_cause = access_fault(is_load, funct3M, ALUResultM[1:0]);
  assign legal_op    = mem_op && (check_cause == CAUSE_NONE);

  // Bus fields come straight from the held EX/MEM values, so they stay
  // stable for the whole access. Loads read the full word.
  assign dmem_we    = MemWriteM;
  assign dmem_addr  = {ALUResultM[31:2], 2'b00};
  assign dmem_be    = is_store ? store_be(funct3M[1:0], ALUResultM[1:0]) : 4'b1111;
  assign dmem_wdata = is_store ? store_wdata(funct3M[1:0], WriteDataM) : 32'h0;

  load_extend u_load_extend (
    .rdata   (dmem_rdata),
    .addr_lo (ALUResultM[1:0]),
    .funct3  (funct3M),
    .result  (load_data)
  );

  // Next-state, bus request, stall and fault decode.
  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    stall     = 1'b0;
    fault     = 1'b0;
    cause     = CAUSE_NONE;
    load_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (mem_op && !legal_op) begin
          fault = 1'b1;
          cause = check_cause;
        end else if (legal_op) begin
          req = 1'b1;
          if (!dmem_gnt) begin
            state_nxt = S_REQ;
            stall     = 1'b1;
          end else if (is_load) begin
            state_nxt = S_RESP;
            stall     = 1'b1;
          end
        end
      end
      S_REQ: begin
        req = 1'b1;
        if (dmem_gnt && is_store) begin
          state_nxt = S_IDLE;
        end else if (wait_cnt == CNT_LAST) begin
          // a load granted in its last allowed cycle still cannot finish
          state_nxt = S_IDLE;
          fault     = 1'b1;
          cause     = CAUSE_TIMEOUT;
        end else begin
          stall = 1'b1;
          if (dmem_gnt) state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (dmem_rvalid) begin
          state_nxt = S_IDLE;
          load_done = 1'b1;
        end else if (wait_cnt == CNT_LAST) begin
          state_nxt = S_IDLE;
          fault     = 1'b1;
          cause     = CAUSE_TIMEOUT;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Held in reset, the combinational controls are forced quiet.
  assign dmem_req    = req & rst;
  assign StallM      = stall & rst;
  assign FaultM      = fault & rst;
  assign FaultCauseM = rst ? cause : CAUSE_NONE;

  // FSM state and wait counter; the counter reads k-1 in the k-th REQ/RESP cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state <= state_nxt;
      if (state == S_IDLE || state_nxt == S_IDLE) wait_cnt <= '0;
      else                                        wait_cnt <= wait_cnt + CW'(1);
    end
  end

  // MEM/WB register: bubble while stalled or faulted, otherwise advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      RdW        <= 5'd0;
      ALUResultW <= 32'h0;
      ReadDataW  <= 32'h0;
      PCPlus4W   <= 32'h0;
    end else if (stall || fault) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
    end else begin
      RegWriteW  <= RegWriteM;
      ResultSrcW <= ResultSrcM;
      RdW        <= RdM;
      ALUResultW <= ALUResultM;
      PCPlus4W   <= PCPlus4M;
      if (load_done) ReadDataW <= load_data;
    end
  end

endmodule

// File: tb/tb_memory_cycle.sv
// Scoreboard bench for memory_cycle: the driver computes each instruction's
// expected outcome from the access rules and queues it; a monitor pops and
// compares whenever the stage retires an instruction (StallM low).
module tb_memory_cycle;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  funct3M;
  logic [4:0]  RdM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RdW;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        StallM, FaultM;
  logic [1:0]  FaultCauseM;

  memory_cycle #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .funct3M(funct3M), .RdM(RdM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .StallM(StallM), .FaultM(FaultM), .FaultCauseM(FaultCauseM)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    int          stalls;
    logic [1:0]  cause;
    logic        regwrite;
    logic [1:0]  resultsrc;
    logic [4:0]  rd;
    logic [31:0] alu, rdata, pc4;
  } exp_t;

  exp_t sb_q[$];
  bit   active = 1'b0;

  // reference view of the MEM/WB register
  logic        m_regwrite = 1'b0;
  logic [1:0]  m_resultsrc = 2'b00;
  logic [4:0]  m_rd = 5'd0;
  logic [31:0] m_alu = 32'h0, m_rdata = 32'h0, m_pc4 = 32'h0;

  // ---------------- reference rules ----------------
  function automatic int acc_bytes(input logic [2:0] f3);
    return 1 << int'(f3[1:0]);
  endfunction

  function automatic logic [1:0] ref_cause(input bit load, input logic [2:0] f3,
                                           input logic [31:0] addr);
    bit legal;
    if (load) legal = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    else      legal = (f3 <= 3'b010);
    if (!legal) return 2'b10;
    if ((int'(addr[1:0]) % acc_bytes(f3)) != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] off,
                                           input logic [2:0] f3);
    longint v;
    int     bits;
    bits = 8 * acc_bytes(f3);
    if (bits == 32) return word;
    v = (longint'(word) >> (8 * int'(off))) & ((64'sd1 << bits) - 1);
    if (!f3[2] && v >= (64'sd1 << (bits - 1))) v = v - (64'sd1 << bits);
    return 32'(v);
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [1:0] off);
    return 4'(((1 << acc_bytes(f3)) - 1) << int'(off));
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (acc_bytes(f3))
      1:       return {24'h0, d[7:0]} * 32'h01010101;
      2:       return {16'h0, d[15:0]} * 32'h00010001;
      default: return d;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Called just after a rising edge. g = cycle of dmem_gnt counted from the
  // issue cycle, r = cycles from grant to rvalid for loads.
  task automatic issue(input bit regw, input logic [1:0] rsrc, input bit memw,
                       input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] wdat,
                       input logic [31:0] pc4, input int g, input int r,
                       input logic [31:0] rdat);
    exp_t       e;
    bit         load, store, legal, real_rv;
    int         comp, stalls;
    logic [1:0] cause;
    store = memw;
    load  = (rsrc == 2'b01) && !memw;
    cause = 2'b00;
    if (load || store) cause = ref_cause(load, f3, alu);
    legal  = (load || store) && (cause == 2'b00);
    stalls = 0;
    if (legal) begin
      comp = store ? g : g + r;
      if (comp <= TIMEOUT) stalls = comp;
      else begin
        stalls = TIMEOUT;
        cause  = 2'b11;
      end
    end
    if (cause != 2'b00) begin
      m_regwrite  = 1'b0;
      m_resultsrc = 2'b00;
    end else begin
      m_regwrite  = regw;
      m_resultsrc = rsrc;
      m_rd        = rd;
      m_alu       = alu;
      m_pc4       = pc4;
      if (load) m_rdata = ref_load(rdat, alu[1:0], f3);
    end
    e.stalls = stalls;  e.cause = cause;
    e.regwrite = m_regwrite;  e.resultsrc = m_resultsrc;  e.rd = m_rd;
    e.alu = m_alu;  e.rdata = m_rdata;  e.pc4 = m_pc4;
    sb_q.push_back(e);

    RegWriteM = regw;  ResultSrcM = rsrc;  MemWriteM = memw;  funct3M = f3;
    RdM = rd;  ALUResultM = alu;  WriteDataM = wdat;  PCPlus4M = pc4;
    for (int k = 0; ; k++) begin
      real_rv     = legal && load && (k == g + r);
      dmem_gnt    = legal && (k == g);
      // spurious rvalid only while the stage is idle or still requesting
      dmem_rvalid = real_rv || ((!legal || k <= g) && ($urandom_range(0, 3) == 0));
      dmem_rdata  = real_rv ? rdat : $urandom();
      @(negedge clk);
      if (k == 0) begin
        check("req_issue", 32'(dmem_req), 32'(legal));
        if (legal) begin
          check("bus_addr", dmem_addr, {alu[31:2], 2'b00});
          check("bus_we", 32'(dmem_we), 32'(store));
          if (store) begin
            check("bus_be", 32'(dmem_be), 32'(ref_be(f3, alu[1:0])));
            check("bus_wdata", dmem_wdata, ref_wdata(f3, wdat));
          end
        end
      end else begin
        check("req_hold", 32'(dmem_req), 32'(k <= g));
      end
      if (StallM !== 1'b1) break;
      if (k > TIMEOUT + 2) begin
        check("stall_bound", 32'(StallM), 32'd0);
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    int   stall_cnt;
    exp_t e;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (!active || !rst) begin
        stall_cnt = 0;
        continue;
      end
      if (StallM === 1'b1) begin
        stall_cnt++;
        @(posedge clk);
        #1;
        check("stall_bubble", 32'({RegWriteW, ResultSrcW}), 32'd0);
      end else begin
        check("retire_expected", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
          check("fault", 32'(FaultM), 32'(e.cause != 2'b00));
          check("fault_cause", 32'(FaultCauseM), 32'(e.cause));
          stall_cnt = 0;
          @(posedge clk);
          #1;
          check("w_regwrite", 32'(RegWriteW), 32'(e.regwrite));
          check("w_resultsrc", 32'(ResultSrcW), 32'(e.resultsrc));
          check("w_rd", 32'(RdW), 32'(e.rd));
          check("w_alu", ALUResultW, e.alu);
          check("w_readdata", ReadDataW, e.rdata);
          check("w_pcplus4", PCPlus4W, e.pc4);
        end
      end
    end
  end

  // ---------------- random traffic ----------------
  task automatic run_random(input int count);
    int         kind, g, r;
    bit         regw, memw;
    logic [1:0] rsrc;
    logic [2:0] f3;
    for (int n = 0; n < count; n++) begin
      kind = int'($urandom_range(0, 9));
      regw = 1'($urandom_range(0, 1));
      memw = (kind >= 6);
      if (kind < 3)      rsrc = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(2, 3));
      else if (kind < 6) rsrc = 2'b01;
      else               rsrc = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
      else if (memw)                 f3 = 3'($urandom_range(0, 2));
      else begin
        f3 = 3'($urandom_range(0, 4));
        if (f3 == 3'b011) f3 = 3'b101;
      end
      g = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 3));
      r = ($urandom_range(0, 9) == 0) ? 17 : int'($urandom_range(1, 3));
      issue(regw, rsrc, memw, f3, 5'($urandom()), $urandom(), $urandom(), $urandom(),
            g, r, $urandom());
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    rst = 1'b0;
    RegWriteM = 1'b1;  ResultSrcM = 2'b01;  MemWriteM = 1'b0;  funct3M = 3'b010;
    RdM = 5'd1;  ALUResultM = 32'h40;  WriteDataM = 32'h0;  PCPlus4M = 32'h4;
    dmem_gnt = 1'b0;  dmem_rvalid = 1'b0;  dmem_rdata = 32'h0;
    #12;
    // a legal load is presented, yet reset must keep everything quiet
    check("rst_regwrite", 32'(RegWriteW), 32'd0);
    check("rst_resultsrc", 32'(ResultSrcW), 32'd0);
    check("rst_rd", 32'(RdW), 32'd0);
    check("rst_alu", ALUResultW, 32'h0);
    check("rst_readdata", ReadDataW, 32'h0);
    check("rst_pcplus4", PCPlus4W, 32'h0);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_stall", 32'(StallM), 32'd0);
    check("rst_fault", 32'(FaultM), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b1;
    active = 1'b1;

    // lw, grant at once, data next cycle
    issue(1'b1, 2'b01, 1'b0, 3'b010, 5'd3, 32'h100, 32'h0, 32'h1004, 0, 1, 32'hDEADBEEF);
    check("lw_data", ReadDataW, 32'hDEADBEEF);
    check("lw_regwrite", 32'(RegWriteW), 32'd1);
    // lb / lbu from the top byte lane
    issue(1'b1, 2'b01, 1'b0, 3'b000, 5'd4, 32'h103, 32'h0, 32'h1008, 0, 2, 32'h80112233);
    check("lb_data", ReadDataW, 32'hFFFFFF80);
    issue(1'b1, 2'b01, 1'b0, 3'b100, 5'd4, 32'h103, 32'h0, 32'h100C, 1, 1, 32'h80112233);
    check("lbu_data", ReadDataW, 32'h00000080);
    // sh upper half, zero-wait grant
    issue(1'b0, 2'b00, 1'b1, 3'b001, 5'd0, 32'h102, 32'h0000ABCD, 32'h1010, 0, 1, 32'h0);
    // misaligned lw
    issue(1'b1, 2'b01, 1'b0, 3'b010, 5'd7, 32'h101, 32'h0, 32'h1014, 0, 1, 32'h0);
    check("misalign_bubble", 32'(RegWriteW), 32'd0);
    // illegal store encoding, then a slow store and a slow load
    issue(1'b0, 2'b00, 1'b1, 3'b011, 5'd0, 32'h200, 32'h55, 32'h1018, 0, 1, 32'h0);
    issue(1'b0, 2'b00, 1'b1, 3'b000, 5'd0, 32'h201, 32'h5A, 32'h101C, 3, 1, 32'h0);
    issue(1'b1, 2'b01, 1'b0, 3'b101, 5'd9, 32'h202, 32'h0, 32'h1020, 2, 4, 32'h8001F00D);
    // grant withheld: timeout in the 16th waiting cycle
    issue(1'b1, 2'b01, 1'b0, 3'b010, 5'd8, 32'h300, 32'h0, 32'h1024, 1000, 1, 32'h0);
    check("timeout_bubble", 32'(RegWriteW), 32'd0);
    // load granted in its last allowed cycle still times out
    issue(1'b1, 2'b01, 1'b0, 3'b010, 5'd8, 32'h304, 32'h0, 32'h1028, TIMEOUT, 1, 32'h1);

    run_random(200);
    active = 1'b0;
    check("queue_drained", 32'(sb_q.size()), 32'd0);

    // reset while a load waits for data, then a late rvalid
    RegWriteM = 1'b1;  ResultSrcM = 2'b01;  MemWriteM = 1'b0;  funct3M = 3'b000;
    RdM = 5'd5;  ALUResultM = 32'h200;  WriteDataM = 32'h0;  PCPlus4M = 32'h2004;
    dmem_gnt = 1'b1;
    @(negedge clk);
    check("pre_rst_stall", 32'(StallM), 32'd1);
    @(posedge clk);
    #1;
    dmem_gnt = 1'b0;
    @(negedge clk);
    check("resp_stall", 32'(StallM), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_readdata", ReadDataW, 32'h0);
    check("midrst_alu", ALUResultW, 32'h0);
    check("midrst_stall", 32'(StallM), 32'd0);
    check("midrst_req", 32'(dmem_req), 32'd0);
    RegWriteM = 1'b0;  ResultSrcM = 2'b00;  funct3M = 3'b000;  RdM = 5'd0;
    ALUResultM = 32'h0;  PCPlus4M = 32'h0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h12345678;
    @(negedge clk);
    check("late_rvalid_stall", 32'(StallM), 32'd0);
    @(posedge clk);
    #1;
    dmem_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("late_readdata", ReadDataW, 32'h0);
    check("late_regwrite", 32'(RegWriteW), 32'd0);
    check("late_rd", 32'(RdW), 32'd0);
    check("late_pcplus4", PCPlus4W, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // hard bound on total run time
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
